// File: rtl/regs_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regs_wb_arbiter
//   Merges two register-file writeback streams (ALU on port A, load unit on
//   port B) into a single register-file write port. Each port has a small
//   FIFO; when both FIFO heads are waiting the arbiter alternates between
//   them. A per-register busy mask tells issue logic which registers still
//   have a write queued.
//
// Handshake: a port transfers an entry on a rising clk edge where valid=1 and
//   ready=1. ready is derived only from the registered FIFO count, so it never
//   depends on valid in the same cycle and a full FIFO does not accept even
//   if it is being popped. A requester holding valid with ready=0 must keep
//   reg/data stable.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   a_valid/a_reg/a_data      ALU writeback request      (in)
//   a_ready                   port A can accept          (out)
//   b_valid/b_reg/b_data      load-unit writeback request (in)
//   b_ready                   port B can accept          (out)
//   write_reg/data            register-file write index/data (out)
//   reg_write_flag            register-file write enable (out)
//   busy                      per-register pending-write mask (out)
// -----------------------------------------------------------------------------
module regs_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic [4:0]  write_reg,
    output logic [31:0] data,
    output logic        reg_write_flag,
    output logic [31:0] busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PA    = 0;
    localparam int PB    = 1;

    // Per-port FIFO storage, index [port][slot]. Storage is never reset;
    // only the valid bits, pointers and counts are.
    logic [4:0]       r_reg_q  [2][DEPTH];
    logic [31:0]      r_data_q [2][DEPTH];
    logic [DEPTH-1:0] r_vld    [2];
    logic [PTR_W-1:0] r_rd_ptr [2];
    logic [PTR_W-1:0] r_wr_ptr [2];
    logic [CNT_W-1:0] r_count  [2];
    logic             r_last_grant_b;   // 1: B won the most recent contention

    logic [1:0]  w_in_valid;
    logic [1:0]  w_ready;
    logic [1:0]  w_push;
    logic [1:0]  w_nonempty;
    logic [1:0]  w_grant;
    logic        w_contend;
    logic [4:0]  w_in_reg    [2];
    logic [31:0] w_in_data   [2];
    logic [4:0]  w_head_reg  [2];
    logic [31:0] w_head_data [2];
    logic [31:0] w_busy;

    always_comb begin
        w_in_valid      = {b_valid, a_valid};
        w_in_reg[PA]    = a_reg;
        w_in_reg[PB]    = b_reg;
        w_in_data[PA]   = a_data;
        w_in_data[PB]   = b_data;
        for (int p = 0; p < 2; p++) begin
            w_ready[p]     = (r_count[p] < CNT_W'(DEPTH));
            w_nonempty[p]  = (r_count[p] != '0);
            w_push[p]      = w_in_valid[p] & w_ready[p];
            w_head_reg[p]  = r_reg_q[p][r_rd_ptr[p]];
            w_head_data[p] = r_data_q[p][r_rd_ptr[p]];
        end
    end

    // Round-robin only matters when both heads wait; otherwise the single
    // non-empty port wins outright.
    always_comb begin
        w_grant   = 2'b00;
        w_contend = w_nonempty[PA] & w_nonempty[PB];
        if (w_contend) begin
            if (r_last_grant_b) w_grant = 2'b01;
            else                w_grant = 2'b10;
        end else if (w_nonempty[PA]) begin
            w_grant = 2'b01;
        end else if (w_nonempty[PB]) begin
            w_grant = 2'b10;
        end
    end

    always_comb begin
        write_reg = '0;
        data      = '0;
        if (w_grant[PA]) begin
            write_reg = w_head_reg[PA];
            data      = w_head_data[PA];
        end else if (w_grant[PB]) begin
            write_reg = w_head_reg[PB];
            data      = w_head_data[PB];
        end
        // Register 0 entries drain through the queue but never write.
        reg_write_flag = (w_grant != 2'b00) && (write_reg != 5'd0);
    end

    always_comb begin
        w_busy = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_vld[p][i]) w_busy[r_reg_q[p][i]] = 1'b1;
            end
        end
        w_busy[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                r_vld[p]    <= '0;
                r_rd_ptr[p] <= '0;
                r_wr_ptr[p] <= '0;
                r_count[p]  <= '0;
            end
            r_last_grant_b <= 1'b1;
        end else begin
            for (int p = 0; p < 2; p++) begin
                // Push and pop never touch the same slot: a push needs a
                // non-full FIFO and a pop a non-empty one.
                if (w_grant[p]) begin
                    r_vld[p][r_rd_ptr[p]] <= 1'b0;
                    r_rd_ptr[p]           <= r_rd_ptr[p] + PTR_W'(1);
                end
                if (w_push[p]) begin
                    r_vld[p][r_wr_ptr[p]] <= 1'b1;
                    r_wr_ptr[p]           <= r_wr_ptr[p] + PTR_W'(1);
                end
                case ({w_push[p], w_grant[p]})
                    2'b10:   r_count[p] <= r_count[p] + CNT_W'(1);
                    2'b01:   r_count[p] <= r_count[p] - CNT_W'(1);
                    default: r_count[p] <= r_count[p];
                endcase
            end
            if (w_contend) r_last_grant_b <= w_grant[PB];
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (w_push[p]) begin
                r_reg_q[p][r_wr_ptr[p]]  <= w_in_reg[p];
                r_data_q[p][r_wr_ptr[p]] <= w_in_data[p];
            end
        end
    end

    assign a_ready = w_ready[PA];
    assign b_ready = w_ready[PB];
    assign busy    = w_busy;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
`timescale 1ns/1ps
module tb_regs_wb_arbiter;
  localparam int DEPTH = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        b_ready;
  logic [4:0]  write_reg;
  logic [31:0] data;
  logic        reg_write_flag;
  logic [31:0] busy;

  regs_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .write_reg(write_reg), .data(data), .reg_write_flag(reg_write_flag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: two queues + last winner ----------------
  // Entry layout: {reg[4:0], data[31:0]}
  logic [36:0] mq_a[$];
  logic [36:0] mq_b[$];
  bit          m_last_b;
  int          e_grant;     // 0 none, 1 A, 2 B
  logic [4:0]  e_reg;
  logic [31:0] e_data;
  logic        e_flag;
  logic [31:0] e_busy;
  logic        e_ar;
  logic        e_br;
  logic [36:0] exp_q[$];    // scoreboard of expected writes (wrap scenario)

  task automatic model_reset();
    mq_a.delete();
    mq_b.delete();
    m_last_b = 1'b1;
  endtask

  task automatic model_expect();
    logic [36:0] head;
    e_ar = (mq_a.size() < DEPTH);
    e_br = (mq_b.size() < DEPTH);
    if (mq_a.size() != 0 && mq_b.size() != 0) e_grant = m_last_b ? 1 : 2;
    else if (mq_a.size() != 0) e_grant = 1;
    else if (mq_b.size() != 0) e_grant = 2;
    else e_grant = 0;
    head = '0;
    if (e_grant == 1) head = mq_a[0];
    else if (e_grant == 2) head = mq_b[0];
    e_reg  = head[36:32];
    e_data = head[31:0];
    e_flag = (e_grant != 0) && (e_reg != 5'd0);
    e_busy = '0;
    foreach (mq_a[i]) e_busy[mq_a[i][36:32]] = 1'b1;
    foreach (mq_b[i]) e_busy[mq_b[i][36:32]] = 1'b1;
    e_busy[0] = 1'b0;
  endtask

  // Applies one clock edge to the model; model_expect must describe this cycle.
  task automatic model_commit(input bit av, input bit bv, input logic [36:0] ae, input logic [36:0] be);
    bit both;
    both = (mq_a.size() != 0) && (mq_b.size() != 0);
    if (e_grant == 1) void'(mq_a.pop_front());
    else if (e_grant == 2) void'(mq_b.pop_front());
    if (both) m_last_b = (e_grant == 2);
    if (av && e_ar) mq_a.push_back(ae);
    if (bv && e_br) mq_b.push_back(be);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_a(input bit v, input logic [4:0] r, input logic [31:0] d);
    a_valid = v; a_reg = r; a_data = d;
  endtask

  task automatic drive_b(input bit v, input logic [4:0] r, input logic [31:0] d);
    b_valid = v; b_reg = r; b_data = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive_a(1'b0, 5'd0, 32'd0);
    drive_b(1'b0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (reg_write_flag !== 1'b0) begin failures++; $display("FAIL reset_flag: got %0b want 0", reg_write_flag); end
    checks++; if (write_reg !== 5'd0) begin failures++; $display("FAIL reset_write_reg: got %0d want 0", write_reg); end
    checks++; if (data !== 32'd0) begin failures++; $display("FAIL reset_data: got %h want 0", data); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL reset_busy: got %h want 0", busy); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_a_ready: got %0b want 1", a_ready); end
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL reset_b_ready: got %0b want 1", b_ready); end
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    checks++; if (reg_write_flag !== 1'b0) begin failures++; $display("FAIL reset_release_flag: got %0b want 0", reg_write_flag); end
  endtask

  task automatic test_single();
    @(negedge clk);
    drive_a(1'b1, 5'd5, 32'h0000_00AA);
    @(negedge clk);
    drive_a(1'b0, 5'd0, 32'd0);
    checks++; if (reg_write_flag !== 1'b1) begin failures++; $display("FAIL single_flag: got %0b want 1", reg_write_flag); end
    checks++; if (write_reg !== 5'd5) begin failures++; $display("FAIL single_write_reg: got %0d want 5", write_reg); end
    checks++; if (data !== 32'h0000_00AA) begin failures++; $display("FAIL single_data: got %h want 000000aa", data); end
    checks++; if (busy !== 32'h0000_0020) begin failures++; $display("FAIL single_busy_c1: got %h want 00000020", busy); end
    @(negedge clk);
    checks++; if (reg_write_flag !== 1'b0) begin failures++; $display("FAIL single_flag_c2: got %0b want 0", reg_write_flag); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL single_busy_c2: got %h want 0", busy); end
  endtask

  task automatic test_pair();
    do_reset();
    @(negedge clk);
    drive_a(1'b1, 5'd3, 32'h11);
    drive_b(1'b1, 5'd4, 32'h22);
    @(negedge clk);   // cycle 1
    drive_a(1'b0, 5'd0, 32'd0);
    drive_b(1'b0, 5'd0, 32'd0);
    checks++; if (write_reg !== 5'd3 || data !== 32'h11 || reg_write_flag !== 1'b1) begin failures++; $display("FAIL pair_c1: got reg=%0d data=%h flag=%0b want reg=3 data=11 flag=1", write_reg, data, reg_write_flag); end
    checks++; if (busy !== 32'h0000_0018) begin failures++; $display("FAIL pair_busy_c1: got %h want 00000018", busy); end
    @(negedge clk);   // cycle 2
    checks++; if (write_reg !== 5'd4 || data !== 32'h22 || reg_write_flag !== 1'b1) begin failures++; $display("FAIL pair_c2: got reg=%0d data=%h flag=%0b want reg=4 data=22 flag=1", write_reg, data, reg_write_flag); end
    drive_a(1'b1, 5'd7, 32'h33);
    drive_b(1'b1, 5'd8, 32'h44);
    @(negedge clk);   // cycle 3: second contention, B's turn
    drive_a(1'b0, 5'd0, 32'd0);
    drive_b(1'b0, 5'd0, 32'd0);
    checks++; if (write_reg !== 5'd8 || data !== 32'h44) begin failures++; $display("FAIL pair_rr_b_first: got reg=%0d data=%h want reg=8 data=44", write_reg, data); end
    @(negedge clk);
    checks++; if (write_reg !== 5'd7 || data !== 32'h33) begin failures++; $display("FAIL pair_rr_a_second: got reg=%0d data=%h want reg=7 data=33", write_reg, data); end
    @(negedge clk);
    checks++; if (reg_write_flag !== 1'b0 || busy !== 32'd0) begin failures++; $display("FAIL pair_idle: got flag=%0b busy=%h want flag=0 busy=0", reg_write_flag, busy); end
  endtask

  task automatic test_reg0();
    do_reset();
    @(negedge clk);
    drive_a(1'b1, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk);   // cycle 1: entry at head, granted
    drive_a(1'b0, 5'd0, 32'd0);
    checks++; if (reg_write_flag !== 1'b0) begin failures++; $display("FAIL reg0_flag: got %0b want 0", reg_write_flag); end
    checks++; if (data !== 32'hFFFF_FFFF || write_reg !== 5'd0) begin failures++; $display("FAIL reg0_head: got reg=%0d data=%h want reg=0 data=ffffffff", write_reg, data); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL reg0_busy_c1: got %h want 0", busy); end
    @(negedge clk);   // cycle 2: popped
    checks++; if (data !== 32'd0 || reg_write_flag !== 1'b0 || busy !== 32'd0) begin failures++; $display("FAIL reg0_popped: got data=%h flag=%0b busy=%h want all 0", data, reg_write_flag, busy); end
  endtask

  task automatic test_wrap();
    int next_r;
    int writes;
    int first_cyc;
    logic [36:0] exp;
    do_reset();
    exp_q.delete();
    next_r = 1; writes = 0; first_cyc = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (reg_write_flag === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL wrap_extra_write: got reg=%0d data=%h want no write", write_reg, data);
        end else begin
          exp = exp_q.pop_front();
          if ({write_reg, data} !== exp) begin failures++; $display("FAIL wrap_order: got reg=%0d data=%h want reg=%0d data=%h", write_reg, data, exp[36:32], exp[31:0]); end
        end
        if (first_cyc < 0) first_cyc = cyc;
        checks++; if (cyc != first_cyc + writes) begin failures++; $display("FAIL wrap_stream: write %0d at cycle %0d want cycle %0d", writes, cyc, first_cyc + writes); end
        writes++;
      end
      if (next_r <= 7) begin
        drive_a(1'b1, 5'(next_r), $urandom());
        if (a_ready === 1'b1) begin
          exp_q.push_back({a_reg, a_data});
          next_r++;
        end
      end else begin
        drive_a(1'b0, 5'd0, 32'd0);
      end
    end
    checks++; if (writes != 7) begin failures++; $display("FAIL wrap_count: got %0d writes want 7", writes); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_leftover: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit pa_v, pb_v, saw_b_stall;
    logic [36:0] pa_e, pb_e;
    int a_sent, n_acc, n_wr;
    do_reset();
    pa_v = 0; pb_v = 0; pa_e = '0; pb_e = '0; saw_b_stall = 0;
    a_sent = 0; n_acc = 0; n_wr = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      model_expect();
      checks++; if (reg_write_flag !== e_flag) begin failures++; $display("FAIL bp_flag c%0d: got %0b want %0b", cyc, reg_write_flag, e_flag); end
      checks++; if (write_reg !== e_reg || data !== e_data) begin failures++; $display("FAIL bp_write c%0d: got reg=%0d data=%h want reg=%0d data=%h", cyc, write_reg, data, e_reg, e_data); end
      checks++; if (busy !== e_busy) begin failures++; $display("FAIL bp_busy c%0d: got %h want %h", cyc, busy, e_busy); end
      checks++; if (a_ready !== e_ar || b_ready !== e_br) begin failures++; $display("FAIL bp_ready c%0d: got a=%0b b=%0b want a=%0b b=%0b", cyc, a_ready, b_ready, e_ar, e_br); end
      if (reg_write_flag === 1'b1) n_wr++;
      if (cyc < 6 && b_ready === 1'b0) saw_b_stall = 1;
      if (!pa_v && a_sent < 10) begin pa_v = 1; pa_e = {5'($urandom_range(1, 15)), 32'($urandom())}; a_sent++; end
      if (cyc < 6) begin
        if (!pb_v) begin pb_v = 1; pb_e = {5'($urandom_range(16, 31)), 32'($urandom())}; end
      end else begin
        pb_v = 0;
      end
      drive_a(pa_v, pa_e[36:32], pa_e[31:0]);
      drive_b(pb_v, pb_e[36:32], pb_e[31:0]);
      if (pa_v && e_ar) n_acc++;
      if (pb_v && e_br) n_acc++;
      model_commit(pa_v, pb_v, pa_e, pb_e);
      if (pa_v && e_ar) pa_v = 0;
      if (pb_v && e_br) pb_v = 0;
    end
    drive_a(1'b0, 5'd0, 32'd0);
    drive_b(1'b0, 5'd0, 32'd0);
    checks++; if (saw_b_stall !== 1'b1) begin failures++; $display("FAIL bp_b_ready_drop: got %0b want 1", saw_b_stall); end
    checks++; if (n_wr != n_acc) begin failures++; $display("FAIL bp_conservation: got %0d writes want %0d", n_wr, n_acc); end
  endtask

  task automatic test_random();
    bit pa_v, pb_v;
    logic [36:0] pa_e, pb_e;
    logic [4:0] r;
    do_reset();
    pa_v = 0; pb_v = 0; pa_e = '0; pb_e = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      model_expect();
      checks++; if (reg_write_flag !== e_flag) begin failures++; $display("FAIL rnd_flag c%0d: got %0b want %0b", cyc, reg_write_flag, e_flag); end
      checks++; if (write_reg !== e_reg || data !== e_data) begin failures++; $display("FAIL rnd_write c%0d: got reg=%0d data=%h want reg=%0d data=%h", cyc, write_reg, data, e_reg, e_data); end
      checks++; if (busy !== e_busy) begin failures++; $display("FAIL rnd_busy c%0d: got %h want %h", cyc, busy, e_busy); end
      checks++; if (a_ready !== e_ar || b_ready !== e_br) begin failures++; $display("FAIL rnd_ready c%0d: got a=%0b b=%0b want a=%0b b=%0b", cyc, a_ready, b_ready, e_ar, e_br); end
      if (cyc < 385) begin
        if (!pa_v && $urandom_range(0, 99) < 60) begin
          r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          pa_v = 1; pa_e = {r, 32'($urandom())};
        end
        if (!pb_v && $urandom_range(0, 99) < 55) begin
          r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          pb_v = 1; pb_e = {r, 32'($urandom())};
        end
      end else begin
        pa_v = 0; pb_v = 0;
      end
      drive_a(pa_v, pa_e[36:32], pa_e[31:0]);
      drive_b(pb_v, pb_e[36:32], pb_e[31:0]);
      model_commit(pa_v, pb_v, pa_e, pb_e);
      if (pa_v && e_ar) pa_v = 0;
      if (pb_v && e_br) pb_v = 0;
    end
    drive_a(1'b0, 5'd0, 32'd0);
    drive_b(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    drive_a(1'b1, 5'd10, 32'hA0A0_A0A0);
    drive_b(1'b1, 5'd20, 32'hB0B0_B0B0);
    repeat (3) @(negedge clk);
    checks++; if (busy !== 32'h0010_0400) begin failures++; $display("FAIL rstmid_pre_busy: got %h want 00100400", busy); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (reg_write_flag !== 1'b0 || write_reg !== 5'd0 || data !== 32'd0) begin failures++; $display("FAIL rstmid_outputs: got flag=%0b reg=%0d data=%h want all 0", reg_write_flag, write_reg, data); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL rstmid_busy: got %h want 0", busy); end
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got a=%0b b=%0b want 1 1", a_ready, b_ready); end
    @(negedge clk);
    drive_a(1'b0, 5'd0, 32'd0);
    drive_b(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      checks++; if (reg_write_flag !== 1'b0 || write_reg !== 5'd0 || busy !== 32'd0) begin failures++; $display("FAIL rstmid_stale c%0d: got flag=%0b reg=%0d busy=%h want 0 0 0", cyc, reg_write_flag, write_reg, busy); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b0;
    drive_a(1'b0, 5'd0, 32'd0);
    drive_b(1'b0, 5'd0, 32'd0);
    model_reset();
    test_reset();
    test_single();
    test_pair();
    test_reg0();
    test_wrap();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
